// File: rtl/rv_mc_pkg.sv
// Shared definitions for the rv_mc multi-cycle RV32I core: FSM states, opcodes,
// ALU control codes, immediate formats and datapath select encodings.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StExecU    = 4'd8,
    StAluWb    = 4'd9,
    StBranch   = 4'd10,
    StJal      = 4'd11,
    StJalrAddr = 4'd12,
    StJalr     = 4'd13,
    StHalt     = 4'd14
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluXor   = 4'b0100;
  localparam logic [3:0] AluSll   = 4'b0101;
  localparam logic [3:0] AluSrl   = 4'b0110;
  localparam logic [3:0] AluSra   = 4'b0111;
  localparam logic [3:0] AluSlt   = 4'b1000;
  localparam logic [3:0] AluSltu  = 4'b1001;
  localparam logic [3:0] AluPassb = 4'b1010;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  localparam logic       SelAddrPc    = 1'b0;
  localparam logic       SelAddrAlu   = 1'b1;
  localparam logic [1:0] SelAPc       = 2'b00;
  localparam logic [1:0] SelAOldPc    = 2'b01;
  localparam logic [1:0] SelARd1      = 2'b10;
  localparam logic [1:0] SelBRd2      = 2'b00;
  localparam logic [1:0] SelBImm      = 2'b01;
  localparam logic [1:0] SelBFour     = 2'b10;
  localparam logic [1:0] SelResAluReg = 2'b00;
  localparam logic [1:0] SelResData   = 2'b01;
  localparam logic [1:0] SelResAlu    = 2'b10;

endpackage

// File: rtl/rv_mc_alu_dec.sv
// funct3/funct7_5 to alu_control decode for register and immediate ALU ops.
module rv_mc_alu_dec
  import rv_mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    case (funct3)
      3'b000:  alu_control = (is_rtype && funct7_5) ? AluSub : AluAdd;
      3'b001:  alu_control = AluSll;
      3'b010:  alu_control = AluSlt;
      3'b011:  alu_control = AluSltu;
      3'b100:  alu_control = AluXor;
      // Bit 30 selects SRA/SRAI for both R and I formats.
      3'b101:  alu_control = funct7_5 ? AluSra : AluSrl;
      3'b110:  alu_control = AluOr;
      default: alu_control = AluAnd;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Main control FSM of the rv_mc multi-cycle RV32I core.
// Define RV_MC_CTRL_TRAP_EN to halt on illegal instructions instead of treating them as NOPs.
module rv_mc_ctrl
  import rv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       cmp_eq,
  input  logic       cmp_lt,
  input  logic       cmp_ltu,
  input  logic       mem_ready,
  output logic       we_pc,
  output logic       we_ir,
  output logic       we_rf,
  output logic       we_mem,
  output logic       sel_mem_addr,
  output logic [1:0] sel_alu_src_a,
  output logic [1:0] sel_alu_src_b,
  output logic [1:0] sel_result,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       halted,
  output logic [3:0] fsm_state
);

`ifdef RV_MC_CTRL_TRAP_EN
  localparam state_e IllegalNext = StHalt;
`else
  localparam state_e IllegalNext = StFetch;
`endif

  state_e     state_q;
  state_e     dispatch;
  logic       br_legal, br_base, br_taken;
  logic [3:0] dec_alu;
  logic       pc_raw, ir_raw, rf_raw, mem_raw;

  rv_mc_alu_dec u_alu_dec (
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .is_rtype    (state_q == StExecR),
    .alu_control (dec_alu)
  );

  // funct3[2:1] picks the compare, funct3[0] inverts it.
  always_comb begin
    br_legal = (funct3[2:1] != 2'b01);
    case (funct3[2:1])
      2'b00:   br_base = cmp_eq;
      2'b10:   br_base = cmp_lt;
      default: br_base = cmp_ltu;
    endcase
    br_taken = br_base ^ funct3[0];
  end

  always_comb begin
    dispatch = IllegalNext;
    case (opcode)
      OpLoad, OpStore: dispatch = StMemAddr;
      OpR:             dispatch = StExecR;
      OpI:             dispatch = StExecI;
      OpBranch:        dispatch = br_legal ? StBranch : IllegalNext;
      OpJal:           dispatch = StJal;
      OpJalr:          dispatch = StJalrAddr;
      OpLui, OpAuipc:  dispatch = StExecU;
      default:         dispatch = IllegalNext;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:                     if (mem_ready) state_q <= StDecode;
        StDecode:                    state_q <= dispatch;
        StMemAddr:                   state_q <= (opcode == OpStore) ? StMemWrite : StMemRead;
        StMemRead:                   if (mem_ready) state_q <= StMemWb;
        StMemWrite:                  if (mem_ready) state_q <= StFetch;
        StExecR, StExecI, StExecU:   state_q <= StAluWb;
        StJal, StJalr:               state_q <= StAluWb;
        StJalrAddr:                  state_q <= StJalr;
        StHalt:                      state_q <= StHalt;
        default:                     state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    pc_raw        = 1'b0;
    ir_raw        = 1'b0;
    rf_raw        = 1'b0;
    mem_raw       = 1'b0;
    sel_mem_addr  = SelAddrPc;
    sel_alu_src_a = SelAPc;
    sel_alu_src_b = SelBFour;
    sel_result    = SelResAlu;
    imm_src       = ImmI;
    alu_control   = AluAdd;
    case (state_q)
      StFetch: begin
        ir_raw = mem_ready;
        pc_raw = mem_ready;
      end
      StDecode: begin
        sel_alu_src_a = SelAOldPc;
        sel_alu_src_b = SelBImm;
        imm_src       = (opcode == OpBranch) ? ImmB : ImmJ;
      end
      StMemAddr: begin
        sel_alu_src_a = SelARd1;
        sel_alu_src_b = SelBImm;
        imm_src       = (opcode == OpStore) ? ImmS : ImmI;
      end
      StMemRead:  sel_mem_addr = SelAddrAlu;
      StMemWb: begin
        sel_result = SelResData;
        rf_raw     = 1'b1;
      end
      StMemWrite: begin
        sel_mem_addr = SelAddrAlu;
        mem_raw      = mem_ready;
      end
      StExecR: begin
        sel_alu_src_a = SelARd1;
        sel_alu_src_b = SelBRd2;
        alu_control   = dec_alu;
      end
      StExecI: begin
        sel_alu_src_a = SelARd1;
        sel_alu_src_b = SelBImm;
        alu_control   = dec_alu;
      end
      StExecU: begin
        sel_alu_src_b = SelBImm;
        imm_src       = ImmU;
        if (opcode == OpLui) alu_control = AluPassb;
        else                 sel_alu_src_a = SelAOldPc;
      end
      StAluWb: begin
        sel_result = SelResAluReg;
        rf_raw     = 1'b1;
      end
      StBranch: begin
        sel_result = SelResAluReg;
        pc_raw     = br_taken;
      end
      StJal, StJalr: begin
        sel_result    = SelResAluReg;
        sel_alu_src_a = SelAOldPc;
        pc_raw        = 1'b1;
      end
      StJalrAddr: begin
        sel_alu_src_a = SelARd1;
        sel_alu_src_b = SelBImm;
      end
      default: ;
    endcase
  end

  // Enables are killed combinationally so reset stops a write in the same cycle.
  assign we_pc  = pc_raw & rst;
  assign we_ir  = ir_raw & rst;
  assign we_rf  = rf_raw & rst;
  assign we_mem = mem_raw & rst;

`ifdef RV_MC_CTRL_TRAP_EN
  assign halted = (state_q == StHalt) & rst;
`else
  assign halted = 1'b0;
`endif

  assign fsm_state = state_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: directed instructions plus random ones
// checked cycle by cycle against a phase-list reference model.
`timescale 1ns/1ps
module tb_rv_mc_ctrl;
  import rv_mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
  logic       mem_ready = 1'b1;
  logic       we_pc, we_ir, we_rf, we_mem, sel_mem_addr, halted;
  logic [1:0] sel_alu_src_a, sel_alu_src_b, sel_result;
  logic [2:0] imm_src;
  logic [3:0] alu_control, fsm_state;

  int n_assert = 0;
  int n_fail   = 0;
  state_e plan[$];

  rv_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu), .mem_ready(mem_ready),
    .we_pc(we_pc), .we_ir(we_ir), .we_rf(we_rf), .we_mem(we_mem),
    .sel_mem_addr(sel_mem_addr), .sel_alu_src_a(sel_alu_src_a),
    .sel_alu_src_b(sel_alu_src_b), .sel_result(sel_result), .imm_src(imm_src),
    .alu_control(alu_control), .halted(halted), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ALU op expected for an R/I arithmetic instruction, straight from the ISA table.
  function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f75, input logic r);
    logic [3:0] tbl [8];
    tbl = '{AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluOr, AluAnd};
    if (f3 == 3'd5 && f75) return AluSra;
    if (r && f3 == 3'd0 && f75) return AluSub;
    return tbl[f3];
  endfunction

  // Sequence of phases an instruction walks through, one entry per non-stalled cycle.
  task automatic build_plan(input logic [6:0] opc, input logic [2:0] f3);
    bit illegal = 0;
    plan.delete();
    plan.push_back(StFetch);
    plan.push_back(StDecode);
    case (opc)
      OpLoad:        begin plan.push_back(StMemAddr); plan.push_back(StMemRead);
                           plan.push_back(StMemWb); end
      OpStore:       begin plan.push_back(StMemAddr); plan.push_back(StMemWrite); end
      OpR:           begin plan.push_back(StExecR); plan.push_back(StAluWb); end
      OpI:           begin plan.push_back(StExecI); plan.push_back(StAluWb); end
      OpLui, OpAuipc: begin plan.push_back(StExecU); plan.push_back(StAluWb); end
      OpJal:         begin plan.push_back(StJal); plan.push_back(StAluWb); end
      OpJalr:        begin plan.push_back(StJalrAddr); plan.push_back(StJalr);
                           plan.push_back(StAluWb); end
      OpBranch:      if (f3 == 3'd2 || f3 == 3'd3) illegal = 1;
                     else plan.push_back(StBranch);
      default:       illegal = 1;
    endcase
`ifdef RV_MC_CTRL_TRAP_EN
    if (illegal) plan.push_back(StHalt);
`else
    if (illegal) plan.push_back(StFetch);
    if (illegal) void'(plan.pop_back());
`endif
  endtask

  task automatic check_cycle(input state_e ph, input logic rd, input logic [6:0] opc,
                             input logic [2:0] f3, input logic f75, input logic taken);
    chk("state", fsm_state, ph);
    chk("we_ir", we_ir, ph == StFetch && rd);
    chk("we_pc", we_pc, (ph == StFetch && rd) || (ph == StBranch && taken) ||
                        ph == StJal || ph == StJalr);
    chk("we_rf", we_rf, ph == StMemWb || ph == StAluWb);
    chk("we_mem", we_mem, ph == StMemWrite && rd);
    chk("halted", halted, ph == StHalt);
    case (ph)
      StFetch: begin
        chk("fetch_addr", sel_mem_addr, 0);
        chk("fetch_res", sel_result, 2);
        chk("fetch_alu", alu_control, AluAdd);
        chk("fetch_b", sel_alu_src_b, 2);
      end
      StDecode: begin
        chk("dec_imm", imm_src, (opc == OpBranch) ? ImmB : ImmJ);
        chk("dec_a", sel_alu_src_a, 1);
        chk("dec_b", sel_alu_src_b, 1);
      end
      StMemAddr: begin
        chk("ma_imm", imm_src, (opc == OpStore) ? ImmS : ImmI);
        chk("ma_a", sel_alu_src_a, 2);
      end
      StMemRead, StMemWrite: chk("mem_addr_sel", sel_mem_addr, 1);
      StMemWb:               chk("wb_res_mem", sel_result, 1);
      StAluWb, StBranch:     chk("wb_res_alu", sel_result, 0);
      StExecR: begin
        chk("r_alu", alu_control, exp_alu(f3, f75, 1'b1));
        chk("r_b", sel_alu_src_b, 0);
      end
      StExecI: begin
        chk("i_alu", alu_control, exp_alu(f3, f75, 1'b0));
        chk("i_imm", imm_src, ImmI);
      end
      StExecU: begin
        chk("u_imm", imm_src, ImmU);
        chk("u_alu", alu_control, (opc == OpLui) ? AluPassb : AluAdd);
      end
      StJal, StJalr: begin
        chk("j_res", sel_result, 0);
        chk("j_a", sel_alu_src_a, 1);
        chk("j_b", sel_alu_src_b, 2);
      end
      StJalrAddr: chk("jalr_imm", imm_src, ImmI);
      default: ;
    endcase
  endtask

  // Called and returns at a falling edge. rmode: 0 ready=1, 1 random, 2 two MEM_READ stalls.
  task automatic run_instr(input logic [31:0] instr, input logic eq, input logic lt,
                           input logic ltu, input int rmode, output int cycles);
    logic [6:0] opc = instr[6:0];
    logic [2:0] f3  = instr[14:12];
    logic       f75 = instr[30];
    logic       base, taken, rd;
    int         stalls = 2;
    int         halt_cycles = 0;
    opcode = opc; funct3 = f3; funct7_5 = f75;
    cmp_eq = eq; cmp_lt = lt; cmp_ltu = ltu;
    base  = (f3[2:1] == 2'b00) ? eq : (f3[2:1] == 2'b10) ? lt : ltu;
    taken = base ^ f3[0];
    build_plan(opc, f3);
    cycles = 0;
    while (plan.size() != 0) begin
      state_e ph;
      ph = plan[0];
      rd = 1'b1;
      if (rmode == 1) rd = ($urandom_range(3) != 0);
      else if (rmode == 2 && ph == StMemRead && stalls > 0) begin rd = 1'b0; stalls--; end
      mem_ready = rd;
      #1;
      check_cycle(ph, rd, opc, f3, f75, taken);
      @(posedge clk);
      cycles++;
      if (ph == StHalt) begin
        halt_cycles++;
        if (halt_cycles == 3) plan.delete();
      end else if (!((ph == StFetch || ph == StMemRead || ph == StMemWrite) && !rd)) begin
        void'(plan.pop_front());
      end
      @(negedge clk);
      if (cycles > 60 && plan.size() != 0) begin
        n_assert++; n_fail++;
        $error("FAIL cycle_budget: observed %0d cycles expected completion", cycles);
        plan.delete();
      end
    end
    if (halt_cycles != 0) begin
      rst = 1'b0;
      #1;
      chk("halt_reset_halted", halted, 0);
      chk("halt_reset_state", fsm_state, StFetch);
      @(negedge clk);
      rst = 1'b1;
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] ins;
    logic [6:0] ops [9];
    ops = '{OpLoad, OpStore, OpR, OpI, OpBranch, OpJal, OpJalr, OpLui, OpAuipc};

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", fsm_state, StFetch);
    chk("rst_we_ir", we_ir, 0);
    chk("rst_we_pc", we_pc, 0);
    chk("rst_we_rf", we_rf, 0);
    chk("rst_we_mem", we_mem, 0);
    chk("rst_halted", halted, 0);
    chk("rst_sel_result", sel_result, 2);
    @(negedge clk);
    rst = 1'b1;

    run_instr(32'h002081B3, 0, 0, 0, 0, cyc); chk("add_cycles", cyc, 4);
    run_instr(32'h00002083, 0, 0, 0, 2, cyc); chk("lw_stall_cycles", cyc, 7);
    run_instr(32'h00102223, 0, 0, 0, 0, cyc); chk("sw_cycles", cyc, 4);
    run_instr(32'h00000463, 1, 0, 0, 0, cyc); chk("beq_taken_cycles", cyc, 3);
    run_instr(32'h00000463, 0, 1, 1, 0, cyc); chk("beq_not_taken_cycles", cyc, 3);
    run_instr(32'h010000EF, 0, 0, 0, 0, cyc); chk("jal_cycles", cyc, 4);
    run_instr(32'h40208133, 0, 0, 0, 0, cyc); chk("sub_cycles", cyc, 4);
    run_instr(32'h000080E7, 0, 0, 0, 0, cyc); chk("jalr_cycles", cyc, 5);
    run_instr(32'h00002063, 1, 1, 1, 0, cyc);
    run_instr(32'hFFFFFFFF, 0, 0, 0, 0, cyc);
`ifdef RV_MC_CTRL_TRAP_EN
    chk("illegal_cycles", cyc, 5);
`else
    chk("illegal_cycles", cyc, 2);
`endif

    for (int i = 0; i < 80; i++) begin
      int k = $urandom_range(9);
      ins = $urandom;
      ins[6:0] = (k == 9) ? 7'($urandom) : ops[k];
      run_instr(ins, 1'($urandom), 1'($urandom), 1'($urandom), 1, cyc);
    end

    // Async reset in the middle of a granted store.
    opcode = OpStore; funct3 = 3'd2; funct7_5 = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("sw_pre_rst_state", fsm_state, StMemWrite);
    chk("sw_pre_rst_we_mem", we_mem, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_we_mem", we_mem, 0);
    chk("mid_rst_we_pc", we_pc, 0);
    chk("mid_rst_state", fsm_state, StFetch);
    @(negedge clk);
    rst = 1'b1;
    run_instr(32'h002081B3, 0, 0, 0, 0, cyc); chk("post_rst_add_cycles", cyc, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mc_ctrl.md
# rv_mc_ctrl

Main control FSM for the multi-cycle RV32I core (`rv_mc`). It takes opcode/funct fields from the instruction register and branch-compare flags from the datapath. It drives every write enable and mux select of the shared ALU/memory datapath, one state per cycle. Memory accesses stall on a ready handshake, so the same controller serves zero-wait and wait-stated RAM.

## Interface
- No parameters.
- `clk` in 1: single core clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `opcode` in 7: instruction register bits [6:0].
- `funct3` in 3: instruction register bits [14:12].
- `funct7_5` in 1: instruction register bit 30.
- `cmp_eq`, `cmp_lt`, `cmp_ltu` in 1 each: rs1/rs2 comparison flags (equal, signed less-than, unsigned less-than), computed combinationally from the register-read latches.
- `mem_ready` in 1: memory completes the current access this cycle.
- `we_pc`, `we_ir`, `we_rf`, `we_mem` out 1 each: PC (also old-PC), IR, register-file and memory write enables.
- `sel_mem_addr` out 1: 0 = pc, 1 = alu_reg_out.
- `sel_alu_src_a` out 2: 00 = pc, 01 = old_pc, 10 = rd1 latch.
- `sel_alu_src_b` out 2: 00 = rd2 latch, 01 = imm_extended, 10 = constant 4.
- `sel_result` out 2: 00 = alu_reg_out, 01 = data_reg_out, 10 = alu_result. This result bus feeds both the PC and rf write data.
- `imm_src` out 3: I=000, S=001, B=010, U=011, J=100.
- `alu_control` out 4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
- `halted` out 1: trap state reached (see Configuration).
- `fsm_state` out 4: current state encoding, for debug and bench.

## Operation
- Outputs are Moore-style (decoded from the state), except that `we_ir`, `we_pc`, `we_mem` in FETCH and MEM_WRITE are ANDed with `mem_ready`.
- States and actions:
  - FETCH: addr=pc, a=pc, b=4, ADD, result=10. On `mem_ready`: `we_ir`=`we_pc`=1, go to DECODE. Otherwise hold.
  - DECODE: a=old_pc, b=imm, ADD, with imm_src B for branches and J otherwise; alu_reg then holds the branch/jal target. Dispatch on opcode:
    - 0000011 / 0100011 → MEM_ADDR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR_ADDR
    - 0110111 / 0010111 → EXEC_U
    - anything else → ILLEGAL handling
  - MEM_ADDR: a=rd1, b=imm (I for load, S for store), ADD. Next state MEM_READ or MEM_WRITE.
  - MEM_READ: addr=alu_reg. Hold until `mem_ready`, then MEM_WB.
  - MEM_WB: result=01, `we_rf`=1, then FETCH.
  - MEM_WRITE: addr=alu_reg, `we_mem`=`mem_ready`. Hold until `mem_ready`, then FETCH.
  - EXEC_R: a=rd1, b=rd2. ALU op from funct3 plus funct7_5 (SUB, SRA). Then ALU_WB.
  - EXEC_I: a=rd1, b=imm I. funct7_5 is honoured only for funct3=101 (SRAI); ADDI never produces SUB. Then ALU_WB.
  - EXEC_U: LUI: b=imm U, PASSB. AUIPC: a=old_pc, b=imm U, ADD. Then ALU_WB.
  - ALU_WB: result=00, `we_rf`=1, then FETCH.
  - BRANCH: result=00, `we_pc`=taken, then FETCH. Taken per funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu. funct3 010/011 are illegal.
  - JAL: result=00, `we_pc`=1; ALU computes old_pc+4 (a=01, b=10, ADD). Then ALU_WB.
  - JALR_ADDR: a=rd1, b=imm I, ADD. Then JALR.
  - JALR: same actions as JAL. Clearing bit 0 of the target is a datapath function.
- Unused selects default to FETCH values. No two write enables other than `we_pc`/`we_ir` are ever high together.

## Timing
- Cycles per instruction with `mem_ready` tied 1:
  - 3: branch
  - 4: R, I, U, JAL, store
  - 5: load, JALR
- Each deasserted-`mem_ready` cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle. State and all enables hold stable while waiting.
- Reset asserted: state=FETCH immediately. All write enables and `halted` are forced 0 while `rst`=0. Selects take their FETCH values.
- Reset mid-instruction: the in-flight instruction is abandoned and no partial write occurs. The first fetch starts on the first rising edge after release.

## Configuration
- `RV_MC_CTRL_TRAP_EN` defined: an illegal opcode or branch funct3 moves DECODE to HALT. In HALT, `halted`=1 and all enables are 0, until reset.
- Undefined: an illegal instruction is a NOP. DECODE goes to FETCH with no writes, and `halted` is tied 0.

## Structure
- Shared package `rv_mc_pkg` holds:
  - state enum
  - opcode constants
  - `alu_control` codes
  - `imm_src` encodings
  - `sel_*` encodings
- Sub-module `rv_mc_alu_dec` is the combinational funct3/funct7_5 → `alu_control` decode, used by EXEC_R and EXEC_I.
- The FSM register and output decode stay in `rv_mc_ctrl`.

## Test plan
- `add x3,x1,x2` (0x002081B3), `mem_ready`=1:
  - States go FETCH, DECODE, EXEC_R, ALU_WB.
  - `alu_control`=0000 in EXEC_R.
  - `we_rf`=1 only in cycle 4.
  - Back in FETCH at cycle 5.
- `lw x1,0(x0)` (0x00002083), `mem_ready` low for 2 cycles in MEM_READ:
  - Instruction takes 7 cycles.
  - `sel_mem_addr`=1 throughout MEM_READ.
  - `we_rf` pulses with `sel_result`=01.
- `sw x1,4(x0)` (0x00102223):
  - `imm_src`=001 in MEM_ADDR.
  - `we_mem`=1 for exactly one cycle.
  - `we_rf` never asserts.
  - Completes in 4 cycles.
- `beq x0,x0,8` (0x00000463):
  - With `cmp_eq`=1: `we_pc`=1 in BRANCH.
  - With `cmp_eq`=0: `we_pc`=0.
  - Either way, back to FETCH after 3 cycles.
- `jal x1,16` (0x010000EF):
  - `we_pc`=1 in JAL with `sel_result`=00.
  - ALU_WB follows with `we_rf`=1.
- 0xFFFFFFFF, plus an async `rst` pulse mid-MEM_WRITE:
  - HALT with `halted`=1 when the macro is defined; otherwise a NOP returning to FETCH.
  - During reset, `we_mem` drops the same cycle, and the state is FETCH after release.
